add_arbiter: RTL and testbench

ADD_ARBITER -- requirements
Module: add_arbiter

---
 rtl/proc_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 44 ++++
 rtl/add_arbiter.sv | 136 +++++++++++++
 tb/tb_add_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared constants for the add_arbiter slice: FSM state encoding and default sizing.
package proc_pkg;

    // FSM encoding: IDLE = no result held, HOLD = result held on the response port
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_NREQ  = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection: picks the first set request at or after ptr,
// wrapping from NREQ-1 back to 0.
// Ports:
//   req   - request vector
//   ptr   - search start index (always < NREQ)
//   grant - one-hot-or-zero grant
//   idx   - index of the granted request (0 when none)
//   any   - at least one request is set
module rr_arbiter
    import proc_pkg::*;
#(
    parameter int unsigned NREQ = DEFAULT_NREQ
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    any
);

    localparam int unsigned IDW = $clog2(NREQ);

    int unsigned cand;

    // Walk the requests starting at ptr; the first hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!any && req[cand[IDW-1:0]]) begin
                any                = 1'b1;
                grant[cand[IDW-1:0]] = 1'b1;
                idx                = cand[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/add_arbiter.sv
// NREQ requesters share one adder. A round-robin arbiter grants one requester
// per accept cycle; its sum is registered and held until the consumer takes it.
// Optional macro ADD_ARBITER_FLAGS_EN adds registered carry / signed-overflow flags.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   req_valid   - per-requester operand valid
//   req_a/req_b - packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready   - one-hot-or-zero acceptance strobe (same cycle as the grant)
//   rsp_valid   - a result is held
//   rsp_id      - owner of the held result
//   rsp_sum     - held sum, modulo 2^WIDTH
//   rsp_ready   - consumer takes the held result
//   rsp_carry   - (ADD_ARBITER_FLAGS_EN) carry out of the MSB
//   rsp_ovf     - (ADD_ARBITER_FLAGS_EN) signed overflow
module add_arbiter
    import proc_pkg::*;
#(
    parameter int unsigned NREQ  = DEFAULT_NREQ,
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]        rsp_sum,
    input  logic                    rsp_ready
`ifdef ADD_ARBITER_FLAGS_EN
    ,
    output logic                    rsp_carry,
    output logic                    rsp_ovf
`endif
);

    localparam int unsigned IDW = $clog2(NREQ);

    logic [0:0]      state_q;
    logic [0:0]      state_d;
    logic            acc_c;
    logic            fire_c;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_any;
    logic [IDW-1:0]  rr_ptr;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and acceptance strobe; rst_n gate keeps req_ready low during reset
    always_comb begin
        state_d   = state_q;
        acc_c     = 1'b0;
        fire_c    = 1'b0;
        req_ready = '0;
        acc_c     = (state_q == IDLE) || ((state_q == HOLD) && rsp_ready);
        fire_c    = acc_c && grant_any && rst_n;
        if (fire_c) begin
            req_ready = grant;
        end
        case (state_q)
            IDLE:    if (fire_c) state_d = HOLD;
            HOLD:    if (rsp_ready && !fire_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rsp_valid = (state_q == HOLD);

    // Operand select feeding the single shared adder
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                op_a = req_a[i*WIDTH +: WIDTH];
                op_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef ADD_ARBITER_FLAGS_EN
    logic [WIDTH:0] sum_ext;
    logic           ovf_c;

    assign sum_ext = {1'b0, op_a} + {1'b0, op_b};
    // Signed overflow: same-sign operands producing a result of the other sign
    assign ovf_c   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum_ext[WIDTH-1] != op_a[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_carry <= 1'b0;
            rsp_ovf   <= 1'b0;
        end else if (fire_c) begin
            rsp_carry <= sum_ext[WIDTH];
            rsp_ovf   <= ovf_c;
        end
    end

    wire [WIDTH-1:0] sum_c = sum_ext[WIDTH-1:0];
`else
    wire [WIDTH-1:0] sum_c = op_a + op_b;
`endif

    // Result capture and round-robin pointer advance on each grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_sum <= '0;
            rsp_id  <= '0;
            rr_ptr  <= '0;
        end else if (fire_c) begin
            rsp_sum <= sum_c;
            rsp_id  <= grant_idx;
            rr_ptr  <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
        end
    end

endmodule

// File: tb/tb_add_arbiter.sv
// Self-checking bench for add_arbiter (NREQ=4, WIDTH=32): table of vectors with
// hand-derived expectations plus a scoreboard fed by a small round-robin model.
module tb_add_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [1:0]            rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_ready = 1'b0;
`ifdef ADD_ARBITER_FLAGS_EN
    logic                  rsp_carry;
    logic                  rsp_ovf;
`endif

    add_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_ready (rsp_ready)
`ifdef ADD_ARBITER_FLAGS_EN
        ,
        .rsp_carry (rsp_carry),
        .rsp_ovf   (rsp_ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  valid;
        logic        rdy;
        logic [3:0]  exp_ready;
        logic        exp_rv;
        logic [1:0]  exp_id;
        logic [31:0] exp_sum;
    } vec_t;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] sum;
        logic        carry;
        logic        ovf;
    } rsp_t;

    logic [31:0] op_a [4];
    logic [31:0] op_b [4];

    int   n_cmp = 0;
    int   n_err = 0;
    rsp_t exp_q[$];
    bit   m_hold = 0;
    int   m_ptr  = 0;
    vec_t tbl [18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] v, input logic r, input logic [3:0] er,
                                input logic erv, input logic [1:0] eid, input logic [31:0] es);
        vec_t t;
        t.valid = v; t.rdy = r; t.exp_ready = er; t.exp_rv = erv; t.exp_id = eid; t.exp_sum = es;
        return t;
    endfunction

    function automatic rsp_t model_rsp(input int g);
        rsp_t  r;
        logic [32:0] s;
        s       = {1'b0, op_a[g]} + {1'b0, op_b[g]};
        r.id    = 2'(g);
        r.sum   = s[31:0];
        r.carry = s[32];
        r.ovf   = (op_a[g][31] == op_b[g][31]) && (s[31] != op_a[g][31]);
        return r;
    endfunction

    // Drive one cycle, check the same-cycle strobe, then check the response after the edge.
    task automatic step(input vec_t v);
        int         g;
        logic [3:0] exp_g;
        req_valid = v.valid;
        rsp_ready = v.rdy;
        #1;
        g = -1;
        if (!m_hold || v.rdy) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && v.valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            end
        end
        exp_g = '0;
        if (g >= 0) exp_g[g] = 1'b1;
        check("req_ready_tbl", 64'(req_ready), 64'(v.exp_ready));
        check("req_ready_mdl", 64'(req_ready), 64'(exp_g));
        if (m_hold && v.rdy && exp_q.size() > 0) void'(exp_q.pop_front());
        if (g >= 0) begin
            exp_q.push_back(model_rsp(g));
            m_ptr  = (g + 1) % NREQ;
            m_hold = 1;
        end else if (m_hold && v.rdy) begin
            m_hold = 0;
        end
        @(posedge clk);
        #1;
        check("rsp_valid", 64'(rsp_valid), 64'(v.exp_rv));
        if (v.exp_rv) begin
            check("rsp_id_tbl", 64'(rsp_id), 64'(v.exp_id));
            check("rsp_sum_tbl", 64'(rsp_sum), 64'(v.exp_sum));
        end
        if (m_hold) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 64'(1), 64'(0));
            end else begin
                check("rsp_id_sb", 64'(rsp_id), 64'(exp_q[0].id));
                check("rsp_sum_sb", 64'(rsp_sum), 64'(exp_q[0].sum));
`ifdef ADD_ARBITER_FLAGS_EN
                check("rsp_carry", 64'(rsp_carry), 64'(exp_q[0].carry));
                check("rsp_ovf", 64'(rsp_ovf), 64'(exp_q[0].ovf));
`endif
            end
        end
    endtask

    initial begin
        op_a[0] = 32'd5;          op_b[0] = 32'd7;
        op_a[1] = 32'hFFFF_FFFF;  op_b[1] = 32'd1;
        op_a[2] = 32'h7FFF_FFFF;  op_b[2] = 32'd1;
        op_a[3] = 32'd100;        op_b[3] = 32'd23;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = op_a[i];
            req_b[i*WIDTH +: WIDTH] = op_b[i];
        end

        //              valid    rdy   ready    rv    id     sum
        tbl[0]  = mk(4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 32'd12);
        tbl[1]  = mk(4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'd0);
        tbl[2]  = mk(4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h8000_0000);
        tbl[3]  = mk(4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'd123);
        tbl[4]  = mk(4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'd12);
        tbl[5]  = mk(4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 32'd12);
        tbl[6]  = mk(4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 32'd12);
        tbl[7]  = mk(4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 32'd12);
        tbl[8]  = mk(4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'd0);
        tbl[9]  = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'd0);
        tbl[10] = mk(4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 32'd12);
        tbl[11] = mk(4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 32'd123);
        tbl[12] = mk(4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 32'd12);
        tbl[13] = mk(4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 32'd12);
        tbl[14] = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'd0);
        tbl[15] = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 32'd0);
        tbl[16] = mk(4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 32'h8000_0000);
        tbl[17] = mk(4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'd0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset_rsp_sum", 64'(rsp_sum), 64'(0));
        check("reset_rsp_id", 64'(rsp_id), 64'(0));
        check("reset_req_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) step(tbl[i]);

        // Reset while holding a result with the pointer at 2
        req_valid = 4'b1100;
        rsp_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("midrst_req_ready", 64'(req_ready), 64'(0));
        check("midrst_rsp_sum", 64'(rsp_sum), 64'(0));
        check("midrst_rsp_id", 64'(rsp_id), 64'(0));
        @(posedge clk);
        #1;
        check("midrst_hold_valid", 64'(rsp_valid), 64'(0));
        @(negedge clk);
        rst_n  = 1'b1;
        m_hold = 0;
        m_ptr  = 0;
        exp_q.delete();
        step(mk(4'b1100, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h8000_0000));
        step(mk(4'b1100, 1'b1, 4'b1000, 1'b1, 2'd3, 32'd123));
        step(mk(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'd0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
